// File: rtl/gpio_filter_pkg.sv
// Shared constants and types for the GPIO input conditioning stage
// (synchroniser, debounce filter, sticky edge flags).
package gpio_filter_pkg;

  localparam int IoRegWidth    = 24;
  localparam int FiltCntWidth  = 4;
  localparam int PrescaleWidth = 16;

  typedef logic [FiltCntWidth-1:0] filt_cnt_t;

  function automatic int word_base(input logic [2:0] sel);
    return int'(sel) * IoRegWidth;
  endfunction

endpackage

// File: rtl/gpio_filter_bit.sv
// One GPIO pin: two-flop synchroniser, tick-driven debounce counter and the
// filtered level, plus combinational pulses marking the edge about to be taken.
module gpio_filter_bit
  import gpio_filter_pkg::*;
#(
  parameter int CntWidth = FiltCntWidth
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pad,
  input  logic                tick,
  input  logic [CntWidth-1:0] filt_len,
  output logic                level,
  output logic                rise,
  output logic                fall
);

  logic                meta;
  logic                sync;
  logic [CntWidth-1:0] cnt;
  logic [CntWidth-1:0] cnt_next;
  logic [CntWidth:0]   cnt_inc;
  logic                level_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pad;
      sync <= meta;
    end
  end

  // Extra bit keeps the >= compare safe when filt_len drops below the count.
  assign cnt_inc = {1'b0, cnt} + {{CntWidth{1'b0}}, 1'b1};

  always_comb begin
    cnt_next   = cnt;
    level_next = level;
    if (filt_len == '0) begin
      cnt_next   = '0;
      level_next = sync;
    end else if (sync == level) begin
      cnt_next = '0;
    end else if (tick) begin
      if (cnt_inc >= {1'b0, filt_len}) begin
        cnt_next   = '0;
        level_next = ~level;
      end else begin
        cnt_next = cnt_inc[CntWidth-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      level <= level_next;
    end
  end

  assign rise = level_next & ~level;
  assign fall = ~level_next & level;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO pad input conditioning: per-pin debounce, shared tick prescaler,
// sticky rise/fall flags with banked write-1-to-clear, and a registered irq.
module gpio_in_filter #(
  parameter int IOWidth       = 72,
  parameter int IoRegWidth    = 24,
  parameter int FiltCntWidth  = 4,
  parameter int PrescaleWidth = 16
) (
  input  logic                     reg_clk,
  input  logic                     reset_in,
  input  logic [IOWidth-1:0]       data_from_gpio,
  input  logic [PrescaleWidth-1:0] prescale,
  input  logic [FiltCntWidth-1:0]  filt_len,
  input  logic [IOWidth-1:0]       rise_en,
  input  logic [IOWidth-1:0]       fall_en,
  input  logic                     clr_strobe,
  input  logic [2:0]               clr_sel,
  input  logic [IoRegWidth-1:0]    clr_rise,
  input  logic [IoRegWidth-1:0]    clr_fall,
  output logic [IOWidth-1:0]       filt_data,
  output logic [IOWidth-1:0]       rise_flag,
  output logic [IOWidth-1:0]       fall_flag,
  output logic                     irq
);

  localparam int NumWords = IOWidth / IoRegWidth;

  logic [PrescaleWidth-1:0] pc;
  logic                     tick;
  logic [IOWidth-1:0]       rise_set;
  logic [IOWidth-1:0]       fall_set;
  logic [IOWidth-1:0]       clr_rise_mask;
  logic [IOWidth-1:0]       clr_fall_mask;

  // >= rather than == so lowering prescale mid-count still ticks promptly.
  assign tick = (pc >= prescale);

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      pc <= '0;
    end else if (tick) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  for (genvar i = 0; i < IOWidth; i++) begin : g_pin
    gpio_filter_bit #(
      .CntWidth(FiltCntWidth)
    ) u_bit (
      .clk     (reg_clk),
      .rst     (reset_in),
      .pad     (data_from_gpio[i]),
      .tick    (tick),
      .filt_len(filt_len),
      .level   (filt_data[i]),
      .rise    (rise_set[i]),
      .fall    (fall_set[i])
    );
  end

  always_comb begin
    clr_rise_mask = '0;
    clr_fall_mask = '0;
    if (clr_strobe) begin
      for (int w = 0; w < NumWords; w++) begin
        if (clr_sel == 3'(w)) begin
          clr_rise_mask[w*IoRegWidth +: IoRegWidth] = clr_rise;
          clr_fall_mask[w*IoRegWidth +: IoRegWidth] = clr_fall;
        end
      end
    end
  end

  // Set is OR'd in after the clear so a simultaneous new edge is never lost.
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      rise_flag <= '0;
      fall_flag <= '0;
      irq       <= 1'b0;
    end else begin
      rise_flag <= (rise_flag & ~clr_rise_mask) | rise_set;
      fall_flag <= (fall_flag & ~clr_fall_mask) | fall_set;
      irq       <= |((rise_flag & rise_en) | (fall_flag & fall_en));
    end
  end

endmodule
